// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl_pkg
//  Purpose  : Shared types and constants for the mem_ctrl front-end.
//             - mem_ctrl_state_e : controller state (INIT while clearing memory,
//                                  RUN while serving requests)
//             - c_RSP_CNT_W      : width of the response-buffer occupancy count
//             - c_RSP_DEPTH      : number of response-buffer entries
//  Revision : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } mem_ctrl_state_e;

    localparam int unsigned c_RSP_CNT_W = 2;
    localparam int unsigned c_RSP_DEPTH = 2;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_ctrl_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl_rsp_fifo
//  Purpose  : Two-entry in-order read-response buffer.
//  Ports    : clk      - clock
//             rst_n    - synchronous active-low reset (empties buffer, clears data)
//             i_push   - write i_wdata into the tail
//             i_wdata  - response data to store
//             i_pop    - drop the head entry
//             o_rdata  - head entry (stable until popped)
//             o_full   - both entries occupied
//             o_empty  - no entry occupied
//  Revision : 1.0  initial release
// ============================================================================
module mem_ctrl_rsp_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ELEM_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [ELEM_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic [ELEM_WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty
);

    logic [ELEM_WIDTH-1:0]  r_mem [c_RSP_DEPTH];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [c_RSP_CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full  = (r_count == c_RSP_CNT_W'(c_RSP_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    // A push into a full buffer is only legal when the head leaves in the
    // same cycle; the slot being written is then the one being vacated.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_RSP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_RSP_CNT_W'(1);
                2'b01:   r_count <= r_count - c_RSP_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : mem_ctrl_rsp_fifo
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : valid/ready request front-end for a single-port memory core with
//             combinational read data. Reads are captured into a 2-entry
//             response buffer (latency 1); writes produce no response.
//  Config   : MEM_CTRL_INIT_EN - when defined, every location is written with
//             INIT_VALUE after reset (one per cycle, busy_o high) before any
//             request is accepted.
//  Ports    : clk_i, rst_ni        - clock, synchronous active-low reset
//             req_valid_i/ready_o  - request handshake
//             req_we_i, req_addr_i, req_wdata_i - request payload
//             rsp_valid_o/ready_i  - read response handshake
//             rsp_rdata_o          - read response data
//             mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i - memory core side
//             busy_o               - init sequence in progress
//  Revision : 1.0  initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned           ELEM_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ELEM_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [ELEM_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ELEM_WIDTH-1:0] rsp_rdata_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [ELEM_WIDTH-1:0] mem_wdata_o,
    input  logic [ELEM_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
);

    mem_ctrl_state_e       r_state;
    logic [ADDR_WIDTH-1:0] w_init_addr;
    logic                  w_accept;
    logic                  w_rsp_push;
    logic                  w_rsp_pop;
    logic                  w_rsp_full;
    logic                  w_rsp_empty;

`ifdef MEM_CTRL_INIT_EN
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

    logic [ADDR_WIDTH-1:0] r_init_cnt;

    // The last init write is issued in the cycle the counter shows the top
    // address, so INIT lasts exactly 2**ADDR_WIDTH cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else if (r_state == INIT) begin
            r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
            if (r_init_cnt == c_LAST_ADDR) begin
                r_state <= RUN;
            end
        end
    end

    assign w_init_addr = r_init_cnt;
    assign busy_o      = (r_state == INIT);
`else
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= RUN;
        end
    end

    assign w_init_addr = '0;
    assign busy_o      = 1'b0;
`endif

    // Reads and writes alike wait for buffer space so responses stay in
    // request order; rst_ni keeps the port closed while reset is held.
    assign req_ready_o = rst_ni && (r_state == RUN) && !w_rsp_full;
    assign w_accept    = req_valid_i && req_ready_o;

    always_comb begin
        if (r_state == INIT) begin
            mem_we_o    = 1'b1;
            mem_addr_o  = w_init_addr;
            mem_wdata_o = INIT_VALUE;
        end else begin
            mem_we_o    = w_accept && req_we_i;
            mem_addr_o  = req_addr_i;
            mem_wdata_o = req_wdata_i;
        end
    end

    assign w_rsp_push  = w_accept && !req_we_i;
    assign w_rsp_pop   = rsp_valid_o && rsp_ready_i;
    assign rsp_valid_o = !w_rsp_empty;

    mem_ctrl_rsp_fifo #(
        .ELEM_WIDTH (ELEM_WIDTH)
    ) u_rsp_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .i_push  (w_rsp_push),
        .i_wdata (mem_rdata_i),
        .i_pop   (w_rsp_pop),
        .o_rdata (rsp_rdata_o),
        .o_full  (w_rsp_full),
        .o_empty (w_rsp_empty)
    );

endmodule : mem_ctrl
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl
//  Purpose  : Self-checking bench for mem_ctrl wired to a behavioural
//             single-port memory (ADDR_WIDTH=4, ELEM_WIDTH=8, INIT 8'hA5).
//             Honours MEM_CTRL_INIT_EN the same way the design does.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;

    logic [7:0] tb_mem  [16];
    logic [7:0] ref_mem [16];
    logic [7:0] exp_q   [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_rsp   = 0;

    mem_ctrl #(
        .ELEM_WIDTH (8),
        .ADDR_WIDTH (4),
        .INIT_VALUE (8'hA5)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy)
    );

    // Single-port memory core: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = tb_mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: handshakes are observed mid-low-phase, i.e. they take
    // effect at the following rising edge.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_q.delete();
`ifdef MEM_CTRL_INIT_EN
            for (int i = 0; i < 16; i++) ref_mem[i] = 8'hA5;
`endif
        end else begin
            if (rsp_valid && rsp_ready) begin
                n_tests++;
                n_rsp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got %h, nothing outstanding", rsp_rdata);
                end else begin
                    logic [7:0] exp;
                    exp = exp_q.pop_front();
                    if (rsp_rdata !== exp) begin
                        n_fail++;
                        $display("FAIL rsp_data: got %h, expected %h", rsp_rdata, exp);
                    end
                end
            end
            if (req_valid && req_ready) begin
                if (req_we) ref_mem[req_addr] = req_wdata;
                else        exp_q.push_back(ref_mem[req_addr]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    // Presents a request and returns at the falling edge after it was taken.
    task automatic issue(input logic we, input logic [3:0] a, input logic [7:0] d);
        int budget = 50;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        #1;
        while (!req_ready && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        n_tests++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL issue_timeout: req_ready=%b, expected 1 within 50 cycles", req_ready);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            #3;
            budget--;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({rsp_valid, rsp_rdata, req_ready} !== {1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b rdata=%h ready=%b, expected 0 00 0",
                     rsp_valid, rsp_rdata, req_ready);
        end
    endtask

`ifdef MEM_CTRL_INIT_EN
    task automatic test_init();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_tests++;
            if ({busy, req_ready, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b1, 4'(i)}) begin
                n_fail++;
                $display("FAIL init_cycle%0d: busy=%b ready=%b we=%b addr=%h, expected 1 0 1 %h",
                         i, busy, req_ready, mem_we, mem_addr, 4'(i));
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if ({busy, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL init_done: busy=%b ready=%b, expected 0 1", busy, req_ready);
        end
    endtask
`else
    task automatic test_no_init();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if ({busy, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL no_init_ready: busy=%b ready=%b, expected 0 1", busy, req_ready);
        end
        for (int i = 0; i < 16; i++) issue(1'b1, 4'(i), 8'hA5);
        idle();
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_init_busy: busy=%b, expected 0", busy);
        end
    endtask
`endif

    task automatic test_streaming();
        int start_rsp;
        rsp_ready = 1'b1;
        @(negedge clk);
        start_rsp = n_rsp;
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = 4'(i);
            #1;
            n_tests++;
            if (req_ready !== 1'b1 || (i > 0 && rsp_valid !== 1'b1)) begin
                n_fail++;
                $display("FAIL stream_cycle%0d: ready=%b rsp_valid=%b, expected 1 1",
                         i, req_ready, rsp_valid);
            end
            @(negedge clk);
        end
        idle();
        drain();
        n_tests++;
        if (n_rsp - start_rsp != 16) begin
            n_fail++;
            $display("FAIL stream_count: got %0d responses, expected 16", n_rsp - start_rsp);
        end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        @(negedge clk);
        issue(1'b1, 4'd5, 8'h3C);
        issue(1'b0, 4'd5, 8'h00);
        idle();
        #1;
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL write_read: valid=%b rdata=%h, expected 1 3c", rsp_valid, rsp_rdata);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_read_pop: valid=%b, expected 0", rsp_valid);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(1'b1, 4'd1, 8'h11);
        issue(1'b1, 4'd2, 8'h22);
        issue(1'b1, 4'd3, 8'h33);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first: ready=%b, expected 1", req_ready);
        end
        @(negedge clk);
        req_addr = 4'd2;
        #1;
        n_tests++;
        if ({req_ready, rsp_valid} !== 2'b11) begin
            n_fail++;
            $display("FAIL bp_second: ready=%b valid=%b, expected 1 1", req_ready, rsp_valid);
        end
        @(negedge clk);
        req_addr = 4'd3;
        #1;
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_third: ready=%b, expected 0", req_ready);
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            n_tests++;
            if ({req_ready, rsp_valid, rsp_rdata} !== {1'b0, 1'b1, 8'h11}) begin
                n_fail++;
                $display("FAIL bp_hold: ready=%b valid=%b rdata=%h, expected 0 1 11",
                         req_ready, rsp_valid, rsp_rdata);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        issue(1'b0, 4'd3, 8'h00);
        idle();
        drain();
    endtask

    task automatic test_reset_mid();
        int cycles = 0;
        @(negedge clk);
        rsp_ready = 1'b0;
        issue(1'b0, 4'd1, 8'h00);
        issue(1'b0, 4'd2, 8'h00);
        idle();
        #1;
        n_tests++;
        if ({rsp_valid, req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_buffered: valid=%b ready=%b, expected 1 0", rsp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
`ifdef MEM_CTRL_INIT_EN
        if ({rsp_valid, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b busy=%b, expected 0 1", rsp_valid, busy);
        end
`else
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b busy=%b, expected 0 0", rsp_valid, busy);
        end
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
`ifdef MEM_CTRL_INIT_EN
        n_tests++;
        if ({busy, mem_addr} !== {1'b1, 4'h0}) begin
            n_fail++;
            $display("FAIL mid_init_restart: busy=%b addr=%h, expected 1 0", busy, mem_addr);
        end
        while (busy === 1'b1 && cycles < 40) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        n_tests++;
        if (cycles != 16) begin
            n_fail++;
            $display("FAIL mid_init_len: busy for %0d cycles, expected 16", cycles);
        end
`else
        n_tests++;
        if ({req_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_ready: ready=%b busy=%b, expected 1 0", req_ready, busy);
        end
`endif
        @(negedge clk);
        issue(1'b0, 4'd1, 8'h00);
        issue(1'b0, 4'd5, 8'h00);
        idle();
        drain();
    endtask

    initial begin
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 8'h00;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        test_reset();
`ifdef MEM_CTRL_INIT_EN
        test_init();
`else
        test_no_init();
`endif
        test_streaming();
        test_write_read();
        test_back_to_back();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_ctrl
`default_nettype wire
